unidad_pc: RTL and testbench

- Program-counter stage of the single-cycle processor.
- Sits directly upstream of the 32-bit Sumador that forms PC+4.
- Holds the PC register and selects the next PC from the sequential, branch or jump sources.
- Handles stall, halt and misaligned-target faults, and counts advanced instructions for debug.

---
 rtl/unidad_pc_pkg.sv | 18 +
 rtl/unidad_pc_sumador.sv | 12 +
 rtl/unidad_pc.sv | 95 +++++++++
 tb/tb_unidad_pc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/unidad_pc_pkg.sv
// Shared definitions for the program-counter stage: FSM encodings and PC constants.
package unidad_pc_pkg;

    typedef enum logic [1:0] {
        ARRANQUE = 2'b00,
        EJECUTA  = 2'b01,
        DETENIDO = 2'b10,
        ILEGAL   = 2'b11
    } estado_t;

    localparam int unsigned INCREMENTO_PC     = 4;
    localparam logic [31:0] PC_INICIO_DEFECTO = 32'h0000_0000;

    function automatic logic alineado(input logic [1:0] bajos);
        return (bajos == 2'b00);
    endfunction

endpackage

// File: rtl/unidad_pc_sumador.sv
// Plain modular adder used to form PC+4; carry out is intentionally dropped.
module Sumador #(
    parameter int ANCHO = 32
) (
    input  logic [ANCHO-1:0] dato1,
    input  logic [ANCHO-1:0] dato2,
    output logic [ANCHO-1:0] result
);

    assign result = dato1 + dato2;

endmodule

// File: rtl/unidad_pc.sv
// Program-counter stage: PC register, next-PC selection, start/run/stop FSM
// and an instruction-advance counter for debug.
module unidad_pc
    import unidad_pc_pkg::*;
#(
    parameter int          ANCHO     = 32,
    parameter logic [ANCHO-1:0] PC_INICIO = ANCHO'(PC_INICIO_DEFECTO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_tomado,
    input  logic [ANCHO-1:0] dir_branch,
    input  logic             jump,
    input  logic [ANCHO-1:0] dir_jump,
    input  logic             halt,
    output logic [ANCHO-1:0] pc,
    output logic [ANCHO-1:0] pc_mas4,
    output logic             pc_valido,
    output logic             falla_alineacion,
    output logic [1:0]       estado,
    output logic [31:0]      contador_instr
);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] pc_q, pc_d;
    logic [31:0]      contador_q, contador_d;
    logic             falla_q, falla_d;
    logic [ANCHO-1:0] candidato;

    Sumador #(.ANCHO(ANCHO)) u_sumador (
        .dato1  (pc_q),
        .dato2  (ANCHO'(INCREMENTO_PC)),
        .result (pc_mas4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= ARRANQUE;
            pc_q       <= PC_INICIO;
            contador_q <= '0;
            falla_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            contador_q <= contador_d;
            falla_q    <= falla_d;
        end
    end

    // Jump outranks branch, so only the winning target is alignment-checked.
    always_comb begin
        if (jump)
            candidato = dir_jump;
        else if (branch_tomado)
            candidato = dir_branch;
        else
            candidato = pc_mas4;
    end

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        contador_d = contador_q;
        falla_d    = falla_q;
        case (estado_q)
            ARRANQUE: estado_d = EJECUTA;
            EJECUTA: begin
                if (halt) begin
                    estado_d = DETENIDO;
                end else if (!stall) begin
                    if (alineado(candidato[1:0])) begin
                        pc_d       = candidato;
                        contador_d = contador_q + 32'd1;
                    end else begin
                        falla_d  = 1'b1;
                        estado_d = DETENIDO;
                    end
                end
            end
            DETENIDO: estado_d = DETENIDO;
            default:  estado_d = DETENIDO;
        endcase
    end

    always_comb begin
        pc_valido = (estado_q == EJECUTA);
    end

    assign pc               = pc_q;
    assign falla_alineacion = falla_q;
    assign estado           = estado_q;
    assign contador_instr   = contador_q;

endmodule

// File: tb/tb_unidad_pc.sv
// Directed scoreboard bench for unidad_pc: each step queues the expected
// post-edge state, drives inputs, and compares after the next rising edge.
module tb_unidad_pc;

    logic        clk = 1'b0;
    logic        reset, stall, branch_tomado, jump, halt;
    logic [31:0] dir_branch, dir_jump;
    logic [31:0] pc, pc_mas4, contador_instr;
    logic        pc_valido, falla_alineacion;
    logic [1:0]  estado;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  est;
        logic [31:0] cont;
        logic        falla;
    } esperado_t;

    esperado_t sb[$];

    unidad_pc #(.ANCHO(32), .PC_INICIO(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_tomado    (branch_tomado),
        .dir_branch       (dir_branch),
        .jump             (jump),
        .dir_jump         (dir_jump),
        .halt             (halt),
        .pc               (pc),
        .pc_mas4          (pc_mas4),
        .pc_valido        (pc_valido),
        .falla_alineacion (falla_alineacion),
        .estado           (estado),
        .contador_instr   (contador_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput(input string step);
        esperado_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard_empty observed=0 expected=1", step);
            return;
        end
        e = sb.pop_front();
        chk({step, ".pc"},        pc,                       e.pc);
        chk({step, ".pc_mas4"},   pc_mas4,                  e.pc + 32'd4);
        chk({step, ".estado"},    32'(estado),              32'(e.est));
        chk({step, ".pc_valido"}, 32'(pc_valido),           32'(e.est == 2'b01));
        chk({step, ".falla"},     32'(falla_alineacion),    32'(e.falla));
        chk({step, ".contador"},  contador_instr,           e.cont);
    endtask

    task automatic applyStimulus(
        input string       step,
        input logic        rst, stl, br,
        input logic [31:0] dbr,
        input logic        jmp,
        input logic [31:0] djmp,
        input logic        hlt,
        input logic [31:0] ePc,
        input logic [1:0]  eEst,
        input logic [31:0] eCont,
        input logic        eFalla
    );
        esperado_t e;
        e.pc = ePc; e.est = eEst; e.cont = eCont; e.falla = eFalla;
        sb.push_back(e);
        reset = rst; stall = stl; branch_tomado = br; dir_branch = dbr;
        jump = jmp; dir_jump = djmp; halt = hlt;
        @(posedge clk);
        #1;
        checkOutput(step);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_tomado = 1'b0; jump = 1'b0; halt = 1'b0;
        dir_branch = '0; dir_jump = '0;
        #1;

        // Reset and sequential run
        applyStimulus("rst0",   1,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b00, 0, 0);
        applyStimulus("arr",    0,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b01, 0, 0);
        applyStimulus("seq4",   0,0,0,32'h0,  0,32'h0,        0, 32'h4,  2'b01, 1, 0);
        applyStimulus("seq8",   0,0,0,32'h0,  0,32'h0,        0, 32'h8,  2'b01, 2, 0);
        applyStimulus("seqC",   0,0,0,32'h0,  0,32'h0,        0, 32'hC,  2'b01, 3, 0);

        // Stall at pc=8 (second stall also tries jump/branch), then branch to 0x40
        applyStimulus("jmp8",   0,0,0,32'h0,  1,32'h8,        0, 32'h8,  2'b01, 4, 0);
        applyStimulus("stall1", 0,1,0,32'h0,  0,32'h0,        0, 32'h8,  2'b01, 4, 0);
        applyStimulus("stall2", 0,1,1,32'h200,1,32'h300,      0, 32'h8,  2'b01, 4, 0);
        applyStimulus("br40",   0,0,1,32'h40, 0,32'h0,        0, 32'h40, 2'b01, 5, 0);
        applyStimulus("seq44",  0,0,0,32'h0,  0,32'h0,        0, 32'h44, 2'b01, 6, 0);

        // Jump beats branch; misaligned jump faults and everything after is ignored
        applyStimulus("jvb",    0,0,1,32'h200,1,32'h100,      0, 32'h100,2'b01, 7, 0);
        applyStimulus("jmis",   0,0,1,32'h200,1,32'h102,      0, 32'h100,2'b10, 7, 1);
        applyStimulus("ign1",   0,0,1,32'h200,1,32'h300,      0, 32'h100,2'b10, 7, 1);
        applyStimulus("ign2",   0,0,0,32'h0,  0,32'h0,        0, 32'h100,2'b10, 7, 1);

        // Wrap of pc_mas4 at the top of the address space
        applyStimulus("rst1",   1,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b00, 0, 0);
        applyStimulus("arr1",   0,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b01, 0, 0);
        applyStimulus("jtop",   0,0,0,32'h0,  1,32'hFFFF_FFFC,0, 32'hFFFF_FFFC, 2'b01, 1, 0);
        applyStimulus("wrap",   0,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b01, 2, 0);
        applyStimulus("seqw",   0,0,0,32'h0,  0,32'h0,        0, 32'h4,  2'b01, 3, 0);

        // Halt beats jump; reset clears DETENIDO
        applyStimulus("j20",    0,0,0,32'h0,  1,32'h20,       0, 32'h20, 2'b01, 4, 0);
        applyStimulus("halt",   0,0,0,32'h0,  1,32'h80,       1, 32'h20, 2'b10, 4, 0);
        applyStimulus("hold",   0,0,0,32'h0,  0,32'h0,        0, 32'h20, 2'b10, 4, 0);
        applyStimulus("rst2",   1,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b00, 0, 0);

        // Reset mid-run with branch pending; ARRANQUE ignores branch; misaligned branch faults
        applyStimulus("arr2",   0,0,0,32'h0,  0,32'h0,        0, 32'h0,  2'b00 | 2'b01, 0, 0);
        applyStimulus("j40",    0,0,0,32'h0,  1,32'h40,       0, 32'h40, 2'b01, 1, 0);
        applyStimulus("rstbr",  1,0,1,32'h80, 0,32'h0,        0, 32'h0,  2'b00, 0, 0);
        applyStimulus("arrbr",  0,0,1,32'h80, 0,32'h0,        0, 32'h0,  2'b01, 0, 0);
        applyStimulus("br80",   0,0,1,32'h80, 0,32'h0,        0, 32'h80, 2'b01, 1, 0);
        applyStimulus("brmis",  0,0,1,32'h81, 0,32'h0,        0, 32'h80, 2'b10, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang
    initial begin
        #20000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
